// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch squash and
// memory-stall hold, plus saturating stall/flush performance counters.
module id_ex_stage #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000,
   parameter int          CTRL_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       id_pc_4,
   input  logic [31:0]       id_inst,
   input  logic [31:0]       id_rs_data,
   input  logic [31:0]       id_rt_data,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              mem_stall,
   input  logic              branch_taken,
   output logic [31:0]       ex_pc_4,
   output logic [31:0]       ex_inst,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [31:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic              ex_valid,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
);

   typedef enum logic [1:0] {
      ACT_LOAD,
      ACT_HOLD,
      ACT_FLUSH,
      ACT_BUBBLE
   } action_t;

   action_t action;
   logic    load_use;
   logic    rs_match;
   logic    rt_match;

   // Hazard detection looks only at registered EX state, never at id_* -> ex_* paths.
   always_comb begin
      rs_match = id_uses_rs && (id_rs == ex_rt);
      rt_match = id_uses_rt && (id_rt == ex_rt);
      load_use = ex_valid && ex_ctrl[0] && (ex_rt != 5'd0) && (rs_match || rt_match);
   end

   always_comb begin
      action = ACT_LOAD;
      if (mem_stall)
         action = ACT_HOLD;
      else if (branch_taken)
         action = ACT_FLUSH;
      else if (load_use)
         action = ACT_BUBBLE;
   end

   // Reset forces the front end to run freely regardless of stall inputs.
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      if (!rst) begin
         pc_write    = !(mem_stall || (load_use && !branch_taken));
         if_id_write = pc_write;
         if_id_flush = branch_taken && !mem_stall;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_pc_4    <= '0;
         ex_inst    <= NOP_INST;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_ctrl    <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_valid   <= 1'b0;
      end else begin
         case (action)
            ACT_HOLD: ;
            ACT_FLUSH, ACT_BUBBLE: begin
               ex_pc_4    <= '0;
               ex_inst    <= NOP_INST;
               ex_rs_data <= '0;
               ex_rt_data <= '0;
               ex_imm     <= '0;
               ex_ctrl    <= '0;
               ex_rt      <= '0;
               ex_rd      <= '0;
               ex_valid   <= 1'b0;
            end
            default: begin
               ex_pc_4    <= id_pc_4;
               ex_inst    <= id_inst;
               ex_rs_data <= id_rs_data;
               ex_rt_data <= id_rt_data;
               ex_imm     <= id_imm;
               ex_ctrl    <= id_ctrl;
               ex_rt      <= id_rt;
               ex_rd      <= id_rd;
               ex_valid   <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (action == ACT_BUBBLE && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (action == ACT_FLUSH && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes model predictions into
// queues, independent monitors pop and compare on each clock phase.
module tb_id_ex_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] id_pc_4, id_inst, id_rs_data, id_rt_data, id_imm;
   logic [15:0] id_ctrl;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt, mem_stall, branch_taken;
   logic [31:0] ex_pc_4, ex_inst, ex_rs_data, ex_rt_data, ex_imm;
   logic [15:0] ex_ctrl;
   logic [4:0]  ex_rt, ex_rd;
   logic        ex_valid, pc_write, if_id_write, if_id_flush;
   logic [15:0] stall_cnt, flush_cnt;

   id_ex_stage #(.NOP_INST(NOP), .CTRL_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_pc_4(id_pc_4), .id_inst(id_inst), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .mem_stall(mem_stall), .branch_taken(branch_taken),
      .ex_pc_4(ex_pc_4), .ex_inst(ex_inst), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
      .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc4, inst, rsd, rtd, imm;
      logic [15:0] ctrl;
      logic [4:0]  rs, rt, rd;
      logic        urs, urt, ms, bt;
   } stim_t;

   typedef struct {
      logic [31:0] pc4, inst, rsd, rtd, imm;
      logic [15:0] ctrl;
      logic [4:0]  rt, rd;
      logic        valid;
      logic [15:0] scnt, fcnt;
   } st_t;

   typedef struct {
      logic pcw, ifw, fl;
   } comb_t;

   st_t   model;
   st_t   state_q[$];
   comb_t comb_q[$];
   int    passed = 0;
   int    total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic st_t reset_state();
      st_t r;
      r = '{pc4: 0, inst: NOP, rsd: 0, rtd: 0, imm: 0, ctrl: 0, rt: 0, rd: 0,
            valid: 0, scnt: 0, fcnt: 0};
      return r;
   endfunction

   function automatic bit hazard(st_t s, stim_t t);
      bit dep;
      dep = (t.urs && t.rs == s.rt) || (t.urt && t.rt == s.rt);
      return s.valid && s.ctrl[0] && s.rt != 0 && dep;
   endfunction

   function automatic st_t next_state(st_t s, stim_t t);
      st_t n;
      n = s;
      if (t.ms) return s;
      if (t.bt || hazard(s, t)) begin
         n = reset_state();
         n.scnt = s.scnt;
         n.fcnt = s.fcnt;
         if (t.bt) n.fcnt = (s.fcnt == 16'hFFFF) ? s.fcnt : s.fcnt + 1;
         else      n.scnt = (s.scnt == 16'hFFFF) ? s.scnt : s.scnt + 1;
         return n;
      end
      n.pc4 = t.pc4; n.inst = t.inst; n.rsd = t.rsd; n.rtd = t.rtd; n.imm = t.imm;
      n.ctrl = t.ctrl; n.rt = t.rt; n.rd = t.rd; n.valid = 1'b1;
      return n;
   endfunction

   task automatic drive(input stim_t t);
      id_pc_4 = t.pc4; id_inst = t.inst; id_rs_data = t.rsd; id_rt_data = t.rtd;
      id_imm = t.imm; id_ctrl = t.ctrl; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
      id_uses_rs = t.urs; id_uses_rt = t.urt; mem_stall = t.ms; branch_taken = t.bt;
   endtask

   task automatic push_comb(input stim_t t, input bit in_rst);
      comb_t c;
      bit stall;
      stall = t.ms || (hazard(model, t) && !t.bt);
      c.pcw = in_rst ? 1'b1 : !stall;
      c.ifw = c.pcw;
      c.fl  = in_rst ? 1'b0 : (t.bt && !t.ms);
      comb_q.push_back(c);
   endtask

   // One clock cycle: drive at negedge, predict, enqueue expectations.
   task automatic step(input stim_t t);
      @(negedge clk);
      drive(t);
      #1;
      push_comb(t, 1'b0);
      model = next_state(model, t);
      state_q.push_back(model);
   endtask

   // Asynchronous reset pulse between edges, with inputs t applied afterwards.
   task automatic reset_step(input stim_t t);
      @(negedge clk);
      drive(t);
      #1;
      rst = 1'b1;
      model = reset_state();
      push_comb(t, 1'b1);
      #1;
      check("async ex_valid", {31'd0, ex_valid}, 32'd0);
      check("async ex_inst", ex_inst, NOP);
      check("async stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("async flush_cnt", {16'd0, flush_cnt}, 32'd0);
      #1;
      rst = 1'b0;
      model = next_state(model, t);
      state_q.push_back(model);
   endtask

   function automatic stim_t idle();
      stim_t t;
      t = '{pc4: 0, inst: NOP, rsd: 0, rtd: 0, imm: 0, ctrl: 0, rs: 0, rt: 0, rd: 0,
            urs: 0, urt: 0, ms: 0, bt: 0};
      return t;
   endfunction

   function automatic stim_t rnd();
      stim_t t;
      t.pc4 = $urandom; t.inst = $urandom; t.rsd = $urandom; t.rtd = $urandom;
      t.imm = $urandom;
      t.ctrl = 16'($urandom) | 16'(($urandom_range(0, 1) == 1) ? 1 : 0);
      t.rs = 5'($urandom_range(0, 3)); t.rt = 5'($urandom_range(0, 3));
      t.rd = 5'($urandom);
      t.urs = 1'($urandom); t.urt = 1'($urandom);
      t.ms = ($urandom_range(0, 9) < 2);
      t.bt = ($urandom_range(0, 9) < 2);
      return t;
   endfunction

   initial begin : comb_monitor
      comb_t c;
      forever begin
         @(negedge clk);
         #2;
         if (comb_q.size() > 0) begin
            c = comb_q.pop_front();
            check("pc_write", {31'd0, pc_write}, {31'd0, c.pcw});
            check("if_id_write", {31'd0, if_id_write}, {31'd0, c.ifw});
            check("if_id_flush", {31'd0, if_id_flush}, {31'd0, c.fl});
         end
      end
   end

   initial begin : state_monitor
      st_t e;
      forever begin
         @(posedge clk);
         #1;
         if (state_q.size() > 0) begin
            e = state_q.pop_front();
            check("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            check("ex_inst", ex_inst, e.inst);
            check("ex_pc_4", ex_pc_4, e.pc4);
            check("ex_rs_data", ex_rs_data, e.rsd);
            check("ex_rt_data", ex_rt_data, e.rtd);
            check("ex_imm", ex_imm, e.imm);
            check("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
            check("ex_rt", {27'd0, ex_rt}, {27'd0, e.rt});
            check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
            check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.scnt});
            check("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.fcnt});
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      stim_t ld, dep, t;
      drive(idle());
      rst = 1'b1;
      model = reset_state();
      #1;
      check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
      check("reset ex_inst", ex_inst, NOP);
      check("reset ex_pc_4", ex_pc_4, 32'd0);
      check("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("reset pc_write", {31'd0, pc_write}, 32'd1);
      check("reset if_id_flush", {31'd0, if_id_flush}, 32'd0);
      #7;
      rst = 1'b0;

      // Plain load followed by a dependent instruction held across the bubble.
      ld = idle();
      ld.inst = 32'h8C22_0004; ld.ctrl = 16'h0003; ld.rt = 5'd2; ld.rd = 5'd7;
      ld.pc4 = 32'h104; ld.imm = 32'd4;
      dep = idle();
      dep.inst = 32'h0041_1820; dep.ctrl = 16'h0002; dep.rs = 5'd2; dep.urs = 1'b1;
      dep.rd = 5'd3; dep.pc4 = 32'h108; dep.rsd = 32'h55;
      step(ld);
      step(dep);
      step(dep);

      // Register 0 never creates a hazard.
      t = ld; t.rt = 5'd0;
      step(t);
      t = dep; t.rs = 5'd0;
      step(t);

      // Branch outranks load-use.
      step(ld);
      t = dep; t.bt = 1'b1;
      step(t);

      // Memory stall with changing inputs, including a pending load-use.
      step(ld);
      for (int unsigned i = 0; i < 3; i++) begin
         t = dep; t.ms = 1'b1; t.inst = $urandom; t.rsd = $urandom;
         step(t);
      end
      step(dep);
      step(dep);
      step(idle());

      // Accumulate five bubbles, leave a valid instruction, then async reset.
      for (int unsigned i = 0; i < 5; i++) begin
         step(ld);
         step(dep);
         step(dep);
      end
      step(ld);
      t = dep; t.ms = 1'b1;
      reset_step(t);
      step(dep);

      for (int unsigned i = 0; i < 400; i++) step(rnd());
      t = rnd(); t.ms = 1'b1;
      reset_step(t);
      for (int unsigned i = 0; i < 100; i++) step(rnd());
      step(idle());

      @(negedge clk);
      @(negedge clk);
      check("state queue drained", state_q.size(), 0);
      check("comb queue drained", comb_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
